// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router and its network interfaces.
//   flit_type_t  - HEAD / BODY / TAIL / HEADTAIL flit tags
//   ni_state_t   - injection NI packet FSM states
//   channel_t    - one flit on a link: valid, type, VC id, payload
//   head_payload - packs destination and source coordinates into a head-flit payload
package router_pkg;

   localparam int unsigned NUM_VCS          = 2;
   localparam int unsigned VC_BITS          = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int unsigned DIM_BITS         = 2;
   localparam int unsigned PAYLOAD_BITS     = 8;
   localparam int unsigned CREDIT_CTR_WIDTH = 4;

   typedef enum logic [1:0] {
      FlitHead     = 2'd0,
      FlitBody     = 2'd1,
      FlitTail     = 2'd2,
      FlitHeadTail = 2'd3
   } flit_type_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StHead = 2'd1,
      StBody = 2'd2
   } ni_state_t;

   typedef struct packed {
      logic                    valid;
      flit_type_t              ftype;
      logic [VC_BITS-1:0]      vcid;
      logic [PAYLOAD_BITS-1:0] data;
   } channel_t;

   // Head payload layout (MSB first): dest_x, dest_y, src_x, src_y; upper bits zero.
   function automatic logic [PAYLOAD_BITS-1:0] head_payload(
      input logic [DIM_BITS-1:0] dx,
      input logic [DIM_BITS-1:0] dy,
      input logic [DIM_BITS-1:0] sx,
      input logic [DIM_BITS-1:0] sy
   );
      logic [PAYLOAD_BITS-1:0] p;
      p = '0;
      p[4*DIM_BITS-1:0] = {dx, dy, sx, sy};
      return p;
   endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin grant of one VC among NUM_VCS requesters.
//   clk, rst     - clock, synchronous active-high reset (pointer -> 0)
//   i_req        - per-VC request (VC has credit)
//   i_advance    - grant was used this cycle; pointer moves to granted+1
//   o_gnt        - one-hot grant
//   o_gnt_idx    - index of the granted VC
//   o_gnt_valid  - some VC is granted
module vc_rr_arbiter
   import router_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_VCS-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_VCS-1:0] o_gnt,
   output logic [VC_BITS-1:0] o_gnt_idx,
   output logic               o_gnt_valid
);

   logic [VC_BITS-1:0] r_ptr;
   logic [VC_BITS-1:0] w_idx;

   // Scan from the pointer upward (wrapping); first requester wins.
   always_comb begin
      o_gnt       = '0;
      o_gnt_idx   = '0;
      o_gnt_valid = 1'b0;
      w_idx       = '0;
      for (int i = 0; i < NUM_VCS; i++) begin
         w_idx = VC_BITS'((32'(r_ptr) + 32'(i)) % NUM_VCS);
         if (!o_gnt_valid && i_req[w_idx]) begin
            o_gnt_valid  = 1'b1;
            o_gnt_idx    = w_idx;
            o_gnt[w_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_advance && o_gnt_valid) begin
         r_ptr <= (o_gnt_idx == VC_BITS'(NUM_VCS - 1)) ? '0 : o_gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/noc_inject_ni.sv
// noc_inject_ni: injection network interface. Turns a packet descriptor plus a payload
// stream into HEAD/BODY/TAIL (or HEADTAIL) flits on the router local inport, with
// per-VC credit flow control and round-robin VC choice per packet.
//   clk, rst              - clock, synchronous active-high reset
//   LOCAL_X, LOCAL_Y      - source coordinates placed in head flits
//   pkt_valid/pkt_ready   - descriptor handshake (pkt_dest_x/y, pkt_len)
//   data_valid/data_ready - payload handshake (data)
//   flit_out              - registered flit to the router
//   credit_in             - one-cycle credit return per VC
//   busy                  - a packet is in flight
//   err_credit_ovf        - sticky: credit returned to a full counter
// Optional build macro NI_STATS_EN adds stat_flits_sent and stat_stall_cycles.
module noc_inject_ni
   import router_pkg::*;
#(
   parameter int unsigned INIT_CREDITS = 4,
   parameter int unsigned LEN_BITS     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DIM_BITS-1:0]     LOCAL_X,
   input  logic [DIM_BITS-1:0]     LOCAL_Y,
   input  logic                    pkt_valid,
   output logic                    pkt_ready,
   input  logic [DIM_BITS-1:0]     pkt_dest_x,
   input  logic [DIM_BITS-1:0]     pkt_dest_y,
   input  logic [LEN_BITS-1:0]     pkt_len,
   input  logic                    data_valid,
   output logic                    data_ready,
   input  logic [PAYLOAD_BITS-1:0] data,
   output channel_t                flit_out,
   input  logic                    credit_in [NUM_VCS],
   output logic                    busy,
   output logic                    err_credit_ovf
`ifdef NI_STATS_EN
   ,
   output logic [31:0]             stat_flits_sent,
   output logic [31:0]             stat_stall_cycles
`endif
);

   localparam logic [CREDIT_CTR_WIDTH-1:0] MaxCredit = CREDIT_CTR_WIDTH'(INIT_CREDITS);

   ni_state_t                   r_state, w_state_next;
   logic [DIM_BITS-1:0]         r_dest_x, r_dest_y;
   logic [LEN_BITS-1:0]         r_len, r_cnt;
   logic [VC_BITS-1:0]          r_vc;
   logic [CREDIT_CTR_WIDTH-1:0] r_credit [NUM_VCS];
   logic [CREDIT_CTR_WIDTH-1:0] w_credit_next [NUM_VCS];
   logic                        r_err;
   channel_t                    r_flit, w_flit_next;

   logic               w_pkt_ready, w_data_ready;
   logic               w_latch, w_head_send, w_body_send, w_last;
   logic               w_ovf;
   logic [NUM_VCS-1:0] w_req, w_gnt, w_dec;
   logic [VC_BITS-1:0] w_gnt_idx;
   logic               w_gnt_valid;

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         w_req[v] = (r_credit[v] != '0);
      end
   end

   vc_rr_arbiter u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_req),
      .i_advance   (w_head_send),
      .o_gnt       (w_gnt),
      .o_gnt_idx   (w_gnt_idx),
      .o_gnt_valid (w_gnt_valid)
   );

   // Packet FSM: next state, handshakes and the flit to register.
   always_comb begin
      w_state_next = r_state;
      w_pkt_ready  = 1'b0;
      w_data_ready = 1'b0;
      w_latch      = 1'b0;
      w_head_send  = 1'b0;
      w_body_send  = 1'b0;
      w_last       = 1'b0;
      w_flit_next  = '0;
      unique case (r_state)
         StIdle: begin
            w_pkt_ready = ~rst;
            if (pkt_valid && w_pkt_ready) begin
               w_latch      = 1'b1;
               w_state_next = StHead;
            end
         end
         StHead: begin
            if (w_gnt_valid) begin
               w_head_send       = 1'b1;
               w_flit_next.valid = 1'b1;
               w_flit_next.vcid  = w_gnt_idx;
               w_flit_next.ftype = (r_len == '0) ? FlitHeadTail : FlitHead;
               w_flit_next.data  = head_payload(r_dest_x, r_dest_y, LOCAL_X, LOCAL_Y);
               w_state_next      = (r_len == '0) ? StIdle : StBody;
            end
         end
         StBody: begin
            // Registered credit only: a credit arriving this cycle is usable next cycle.
            w_data_ready = ~rst && (r_credit[r_vc] != '0);
            if (data_valid && w_data_ready) begin
               w_body_send       = 1'b1;
               w_last            = (r_cnt == r_len - LEN_BITS'(1));
               w_flit_next.valid = 1'b1;
               w_flit_next.vcid  = r_vc;
               w_flit_next.ftype = w_last ? FlitTail : FlitBody;
               w_flit_next.data  = data;
               if (w_last) begin
                  w_state_next = StIdle;
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         w_dec[v] = w_head_send ? w_gnt[v] : (w_body_send && (r_vc == VC_BITS'(v)));
      end
   end

   // Credit counters: send and return in the same cycle cancel out.
   always_comb begin
      w_ovf = 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
         w_credit_next[v] = r_credit[v];
         if (credit_in[v] && !w_dec[v]) begin
            if (r_credit[v] >= MaxCredit) begin
               w_ovf = 1'b1;
            end else begin
               w_credit_next[v] = r_credit[v] + 1'b1;
            end
         end else if (!credit_in[v] && w_dec[v]) begin
            w_credit_next[v] = r_credit[v] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_flit   <= '0;
         r_err    <= 1'b0;
         r_dest_x <= '0;
         r_dest_y <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_vc     <= '0;
         for (int v = 0; v < NUM_VCS; v++) begin
            r_credit[v] <= MaxCredit;
         end
      end else begin
         r_state <= w_state_next;
         r_flit  <= w_flit_next;
         if (w_ovf) begin
            r_err <= 1'b1;
         end
         if (w_latch) begin
            r_dest_x <= pkt_dest_x;
            r_dest_y <= pkt_dest_y;
            r_len    <= pkt_len;
         end
         if (w_head_send) begin
            r_vc  <= w_gnt_idx;
            r_cnt <= '0;
         end
         if (w_body_send) begin
            r_cnt <= r_cnt + 1'b1;
         end
         for (int v = 0; v < NUM_VCS; v++) begin
            r_credit[v] <= w_credit_next[v];
         end
      end
   end

   assign pkt_ready      = w_pkt_ready;
   assign data_ready     = w_data_ready;
   assign flit_out       = r_flit;
   assign busy           = (r_state != StIdle);
   assign err_credit_ovf = r_err;

`ifdef NI_STATS_EN
   logic [31:0] r_stat_flits, r_stat_stall;
   logic        w_stall;

   // Stall means blocked on credit, not merely waiting for payload.
   assign w_stall = ((r_state == StHead) && !w_gnt_valid) ||
                    ((r_state == StBody) && (r_credit[r_vc] == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_flits <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_head_send || w_body_send) begin
            r_stat_flits <= r_stat_flits + 32'd1;
         end
         if (w_stall) begin
            r_stat_stall <= r_stat_stall + 32'd1;
         end
      end
   end

   assign stat_flits_sent   = r_stat_flits;
   assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_noc_inject_ni.sv
// tb_noc_inject_ni: self-checking bench for noc_inject_ni (table of packets plus
// hand-written reset, credit-stall and credit-overflow sequences).
module tb_noc_inject_ni;
   import router_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [DIM_BITS-1:0]     local_x, local_y;
   logic                    pkt_valid, pkt_ready;
   logic [DIM_BITS-1:0]     pkt_dest_x, pkt_dest_y;
   logic [3:0]              pkt_len;
   logic                    data_valid, data_ready;
   logic [PAYLOAD_BITS-1:0] data;
   channel_t                flit_out;
   logic                    credit_in [NUM_VCS];
   logic                    busy, err_credit_ovf;
`ifdef NI_STATS_EN
   logic [31:0]             stat_flits_sent, stat_stall_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   noc_inject_ni #(
      .INIT_CREDITS (4),
      .LEN_BITS     (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .LOCAL_X           (local_x),
      .LOCAL_Y           (local_y),
      .pkt_valid         (pkt_valid),
      .pkt_ready         (pkt_ready),
      .pkt_dest_x        (pkt_dest_x),
      .pkt_dest_y        (pkt_dest_y),
      .pkt_len           (pkt_len),
      .data_valid        (data_valid),
      .data_ready        (data_ready),
      .data              (data),
      .flit_out          (flit_out),
      .credit_in         (credit_in),
      .busy              (busy),
      .err_credit_ovf    (err_credit_ovf)
`ifdef NI_STATS_EN
      ,
      .stat_flits_sent   (stat_flits_sent),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   typedef struct {
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [3:0]  len;
      logic [31:0] pl;    // payload bytes, first at [7:0]
      logic [7:0]  head;  // expected head payload
      int          vc;
      int          c0;    // credit[0] after the packet
      int          c1;    // credit[1] after the packet
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      pkt_valid  = 1'b0;
      data_valid = 1'b0;
      credit_in[0] = 1'b0;
      credit_in[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs one packet to completion; optionally returns one VC0 credit after 3 stalled cycles.
   task automatic run_pkt(input vec_t v, input bit pulse_on_stall);
      int         cyc, nfl, idx, last_cyc, stall, pulse_cyc;
      bit         done, hs_pkt, hs_dat, saw_ready;
      logic [7:0] exp_data;
      flit_type_t exp_t;
      cyc = 0; nfl = 0; idx = 0; last_cyc = 0; stall = 0; pulse_cyc = -1;
      done = 0; saw_ready = 0;
      pkt_dest_x = v.dx;
      pkt_dest_y = v.dy;
      pkt_len    = v.len;
      pkt_valid  = 1'b1;
      data_valid = (v.len != 0);
      data       = v.pl[7:0];
      while (!done && cyc < 40) begin
         hs_pkt = pkt_valid && pkt_ready;
         hs_dat = data_valid && data_ready;
         if (data_ready) saw_ready = 1;
         @(posedge clk);
         @(negedge clk);
         cyc++;
         credit_in[0] = 1'b0;
         if (hs_pkt) pkt_valid = 1'b0;
         if (hs_dat) idx++;
         data_valid = (idx < int'(v.len));
         data       = (idx < 4) ? v.pl[8*idx +: 8] : 8'h00;
         if (flit_out.valid) begin
            if (nfl > int'(v.len)) begin
               chk("extra_flit", nfl, int'(v.len));
               done = 1;
            end else begin
               if (nfl == 0) begin
                  exp_t    = (v.len == 0) ? FlitHeadTail : FlitHead;
                  exp_data = v.head;
               end else begin
                  exp_t    = (nfl == int'(v.len)) ? FlitTail : FlitBody;
                  exp_data = v.pl[8*(nfl-1) +: 8];
               end
               chk("flit_type", int'(flit_out.ftype), int'(exp_t));
               chk("flit_data", int'(flit_out.data), int'(exp_data));
               chk("flit_vc", int'(flit_out.vcid), v.vc);
               if (nfl > 0 && pulse_cyc < 0) chk("flit_gap", cyc - last_cyc, 1);
               if (pulse_cyc >= 0 && exp_t == FlitTail) chk("tail_after_credit", cyc - pulse_cyc, 2);
               last_cyc = cyc;
               nfl++;
               if (exp_t == FlitTail || exp_t == FlitHeadTail) done = 1;
            end
         end
         if (pulse_on_stall && pulse_cyc < 0 && busy && data_valid && !data_ready) begin
            stall++;
            if (stall == 3) begin
               chk("flits_before_stall", nfl, 4);
               credit_in[0] = 1'b1;
               pulse_cyc = cyc;
            end
         end
      end
      credit_in[0] = 1'b0;
      pkt_valid    = 1'b0;
      data_valid   = 1'b0;
      chk("pkt_done", int'(done), 1);
      if (v.len == 0) chk("len0_no_data_ready", int'(saw_ready), 0);
      chk("idle_after_pkt", int'(pkt_ready), 1);
      chk("credit0_after", int'(dut.r_credit[0]), v.c0);
      chk("credit1_after", int'(dut.r_credit[1]), v.c1);
   endtask

   initial begin
      vec_t s1;
      //          dx    dy    len   payload        head   vc c0 c1
      vecs[0] = '{2'd3, 2'd0, 4'd2, 32'h0000_0B0A, 8'hC6, 0, 1, 4};
      vecs[1] = '{2'd0, 2'd1, 4'd0, 32'h0000_0000, 8'h16, 1, 1, 3};
      vecs[2] = '{2'd2, 2'd3, 4'd0, 32'h0000_0000, 8'hB6, 0, 0, 3};
      vecs[3] = '{2'd1, 2'd1, 4'd1, 32'h0000_0005, 8'h56, 1, 0, 1};
      vecs[4] = '{2'd3, 2'd3, 4'd0, 32'h0000_0000, 8'hF6, 1, 0, 0};  // VC0 empty -> VC1
      s1      = '{2'd1, 2'd0, 4'd4, 32'h0403_0201, 8'h46, 0, 0, 4};

      local_x = 2'd1; local_y = 2'd2;
      pkt_dest_x = '0; pkt_dest_y = '0; pkt_len = '0; data = '0;
      rst = 1'b1; pkt_valid = 1'b0; data_valid = 1'b0;
      credit_in[0] = 1'b0; credit_in[1] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pkt_ready", int'(pkt_ready), 0);
      chk("rst_data_ready", int'(data_ready), 0);
      chk("rst_flit_valid", int'(flit_out.valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err_credit_ovf), 0);
      chk("rst_credit0", int'(dut.r_credit[0]), 4);
      chk("rst_credit1", int'(dut.r_credit[1]), 4);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_pkt_ready", int'(pkt_ready), 1);

      for (int i = 0; i < 5; i++) begin
         run_pkt(vecs[i], 1'b0);
      end
      chk("no_ovf_after_table", int'(err_credit_ovf), 0);

      // Credit stall on VC0 and resume after one returned credit.
      do_reset();
      run_pkt(s1, 1'b1);

      // Credit returned to a full counter.
      do_reset();
      credit_in[1] = 1'b1;
      @(negedge clk);
      credit_in[1] = 1'b0;
      chk("ovf_credit1_sat", int'(dut.r_credit[1]), 4);
      chk("ovf_flag", int'(err_credit_ovf), 1);
      @(negedge clk);
      chk("ovf_sticky", int'(err_credit_ovf), 1);
      do_reset();
      chk("ovf_cleared", int'(err_credit_ovf), 0);

      // Send and credit return on VC0 in the same cycle.
      pkt_dest_x = 2'd2; pkt_dest_y = 2'd2; pkt_len = 4'd0; pkt_valid = 1'b1;
      @(negedge clk);
      pkt_valid    = 1'b0;
      credit_in[0] = 1'b1;
      @(negedge clk);
      credit_in[0] = 1'b0;
      chk("simul_flit_valid", int'(flit_out.valid), 1);
      chk("simul_flit_type", int'(flit_out.ftype), int'(FlitHeadTail));
      chk("simul_credit0", int'(dut.r_credit[0]), 4);
      chk("simul_no_ovf", int'(err_credit_ovf), 0);

      // Reset while in BODY abandons the packet.
      do_reset();
      pkt_dest_x = 2'd3; pkt_dest_y = 2'd1; pkt_len = 4'd3; pkt_valid = 1'b1;
      @(negedge clk);
      pkt_valid = 1'b0;
      @(negedge clk);
      chk("body_busy", int'(busy), 1);
      chk("body_head_valid", int'(flit_out.valid), 1);
      chk("body_credit0", int'(dut.r_credit[0]), 3);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_pkt_ready", int'(pkt_ready), 0);
      chk("midrst_data_ready", int'(data_ready), 0);
      chk("midrst_flit_valid", int'(flit_out.valid), 0);
      chk("midrst_credit0", int'(dut.r_credit[0]), 4);
      chk("midrst_credit1", int'(dut.r_credit[1]), 4);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_pkt_ready", int'(pkt_ready), 1);
      chk("postrst_flit_valid", int'(flit_out.valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
